// File: rtl/sdcard_bus_arbiter.sv
// sdcard_bus_arbiter
// Arbitrates the SD bus between the command and data engines. Each owner
// holds the bus until its done pulse. A card-busy phase on DAT0 can follow,
// and removing the card or requesting power-down aborts the current owner.
// Optional feature: define SDCARD_ARB_BUSY_TIMEOUT_EN to enable the
// busy-wait timeout driven by timeout_limit_i.
module sdcard_bus_arbiter (
    input  logic        PCLK_i,
    input  logic        PRESET_i,
    input  logic        cmd_req_i,
    input  logic        cmd_done_i,
    input  logic        dat_req_i,
    input  logic        dat_done_i,
    input  logic        busy_chk_i,
    input  logic        dat0_i,
    input  logic        card_present_i,
    input  logic        power_down_i,
    input  logic        access_granted_i,
    input  logic [15:0] timeout_limit_i,
    output logic        cmd_gnt_o,
    output logic        dat_gnt_o,
    output logic [2:0]  bus_state_o,
    output logic        abort_o,
    output logic        timeout_err_o,
    output logic        security_err_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        DATA      = 3'd2,
        BUSY_WAIT = 3'd3,
        ABORT     = 3'd4,
        PWRDN     = 3'd5
    } busState_t;

    busState_t   r_state;
    busState_t   w_nextState;
    logic        r_lastOwnerDat;
    logic [15:0] r_busyCount;
    logic        r_dat0High;
    logic        r_secErr;
    logic        r_timeoutErr;
    logic        w_secErr;
    logic        w_timeout;
    logic        w_abortCond;
    logic        w_timeoutHit;

`ifdef SDCARD_ARB_BUSY_TIMEOUT_EN
    // Busy phase has run too long while the card still holds DAT0 low
    assign w_timeoutHit = (timeout_limit_i != 16'd0) && !dat0_i &&
                          (r_busyCount >= timeout_limit_i);
`else
    logic w_unused;
    assign w_timeoutHit = 1'b0;
    assign w_unused     = ^{timeout_limit_i, r_busyCount};
`endif

    assign w_abortCond    = !card_present_i || power_down_i;
    assign bus_state_o    = r_state;
    assign cmd_gnt_o      = (r_state == CMD);
    assign dat_gnt_o      = (r_state == DATA);
    assign abort_o        = (r_state == ABORT);
    assign timeout_err_o  = r_timeoutErr;
    assign security_err_o = r_secErr;

    // Next-state selection and one-cycle error flags
    always_comb begin
        w_nextState = IDLE;
        w_secErr    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (power_down_i) begin
                    w_nextState = PWRDN;
                end else if (!card_present_i) begin
                    w_nextState = IDLE;
                end else if (cmd_req_i || dat_req_i) begin
                    if (!access_granted_i) begin
                        w_secErr = 1'b1;
                    end else if (cmd_req_i && (!dat_req_i || r_lastOwnerDat)) begin
                        w_nextState = CMD;
                    end else begin
                        w_nextState = DATA;
                    end
                end
            end
            CMD: begin
                if (w_abortCond) begin
                    w_nextState = ABORT;
                end else if (cmd_done_i) begin
                    w_nextState = busy_chk_i ? BUSY_WAIT : IDLE;
                end else begin
                    w_nextState = CMD;
                end
            end
            DATA: begin
                if (w_abortCond) begin
                    w_nextState = ABORT;
                end else if (dat_done_i) begin
                    w_nextState = busy_chk_i ? BUSY_WAIT : IDLE;
                end else begin
                    w_nextState = DATA;
                end
            end
            BUSY_WAIT: begin
                if (w_abortCond) begin
                    w_nextState = ABORT;
                end else if (w_timeoutHit) begin
                    w_nextState = ABORT;
                    w_timeout   = 1'b1;
                end else if (dat0_i && r_dat0High) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = BUSY_WAIT;
                end
            end
            ABORT: begin
                w_nextState = power_down_i ? PWRDN : IDLE;
            end
            PWRDN: begin
                w_nextState = power_down_i ? PWRDN : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register, round-robin owner memory, busy counter and flag outputs
    always_ff @(posedge PCLK_i) begin
        if (PRESET_i) begin
            r_state        <= IDLE;
            r_lastOwnerDat <= 1'b1;
            r_busyCount    <= 16'd0;
            r_dat0High     <= 1'b0;
            r_secErr       <= 1'b0;
            r_timeoutErr   <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_secErr     <= w_secErr;
            r_timeoutErr <= w_timeout;
            if (r_state == IDLE && w_nextState == CMD) begin
                r_lastOwnerDat <= 1'b0;
            end else if (r_state == IDLE && w_nextState == DATA) begin
                r_lastOwnerDat <= 1'b1;
            end
            if (r_state != BUSY_WAIT) begin
                r_busyCount <= 16'd0;
                r_dat0High  <= 1'b0;
            end else begin
                if (r_busyCount != 16'hFFFF) begin
                    r_busyCount <= r_busyCount + 16'd1;
                end
                r_dat0High <= dat0_i;
            end
        end
    end

endmodule

// File: tb/tb_sdcard_bus_arbiter.sv
// tb_sdcard_bus_arbiter
// Directed stimulus against a cycle-level behavioural model of the bus
// ownership rules; outputs compared every cycle, plus literal expectations
// for the named scenarios. Honours SDCARD_ARB_BUSY_TIMEOUT_EN.
module tb_sdcard_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmdReq = 1'b0, cmdDone = 1'b0, datReq = 1'b0, datDone = 1'b0;
    logic        busyChk = 1'b0, dat0 = 1'b1, cardPresent = 1'b1;
    logic        powerDown = 1'b0, accessGranted = 1'b1;
    logic [15:0] timeoutLimit = 16'd100;
    logic        cmdGnt, datGnt, abortPulse, timeoutErr, securityErr;
    logic [2:0]  busState;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Scenario observation counters (sampled each falling edge)
    int secSeen = 0, busySeen = 0, abortSeen = 0, toSeen = 0, nonIdleSeen = 0;

    // Behavioural model: owner/phase, round-robin memory, busy bookkeeping
    int mState = 0;
    bit mLastWasCmd = 1'b0;
    int mBusyCycles = 0;
    int mHighRun = 0;
    bit mSec = 1'b0, mTo = 1'b0;

    sdcard_bus_arbiter dut (
        .PCLK_i(clk), .PRESET_i(reset),
        .cmd_req_i(cmdReq), .cmd_done_i(cmdDone),
        .dat_req_i(datReq), .dat_done_i(datDone),
        .busy_chk_i(busyChk), .dat0_i(dat0),
        .card_present_i(cardPresent), .power_down_i(powerDown),
        .access_granted_i(accessGranted), .timeout_limit_i(timeoutLimit),
        .cmd_gnt_o(cmdGnt), .dat_gnt_o(datGnt), .bus_state_o(busState),
        .abort_o(abortPulse), .timeout_err_o(timeoutErr),
        .security_err_o(securityErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Model update from the inputs seen at each rising edge
    always @(posedge clk) begin
        int nxt;
        bit lost;
        if (reset) begin
            mState = 0; mLastWasCmd = 1'b0; mBusyCycles = 0; mHighRun = 0;
            mSec = 1'b0; mTo = 1'b0;
        end else begin
            nxt = mState;
            mSec = 1'b0;
            mTo = 1'b0;
            lost = !cardPresent || powerDown;
            case (mState)
                0: begin
                    nxt = 0;
                    if (powerDown) nxt = 5;
                    else if (cardPresent && (cmdReq || datReq)) begin
                        if (!accessGranted) mSec = 1'b1;
                        else begin
                            if (cmdReq && datReq) nxt = mLastWasCmd ? 2 : 1;
                            else nxt = cmdReq ? 1 : 2;
                            mLastWasCmd = (nxt == 1);
                        end
                    end
                end
                1, 2: begin
                    if (lost) nxt = 4;
                    else if ((mState == 1 && cmdDone) || (mState == 2 && datDone))
                        nxt = busyChk ? 3 : 0;
                end
                3: begin
                    if (lost) nxt = 4;
`ifdef SDCARD_ARB_BUSY_TIMEOUT_EN
                    else if (timeoutLimit != 0 && !dat0 && mBusyCycles >= timeoutLimit) begin
                        nxt = 4;
                        mTo = 1'b1;
                    end
`endif
                    else if (dat0 && mHighRun >= 1) nxt = 0;
                end
                4: nxt = powerDown ? 5 : 0;
                5: nxt = powerDown ? 5 : 0;
                default: nxt = 0;
            endcase
            if (mState == 3 && nxt == 3) begin
                if (mBusyCycles < 65535) mBusyCycles++;
                mHighRun = dat0 ? mHighRun + 1 : 0;
            end else begin
                mBusyCycles = 0;
                mHighRun = 0;
            end
            mState = nxt;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("bus_state", 16'(busState), 16'(mState));
            checkOutput("cmd_gnt", 16'(cmdGnt), 16'(mState == 1));
            checkOutput("dat_gnt", 16'(datGnt), 16'(mState == 2));
            checkOutput("abort", 16'(abortPulse), 16'(mState == 4));
            checkOutput("timeout_err", 16'(timeoutErr), 16'(mTo));
            checkOutput("security_err", 16'(securityErr), 16'(mSec));
            if (securityErr) secSeen++;
            if (busState == 3'd3) busySeen++;
            if (abortPulse) abortSeen++;
            if (timeoutErr) toSeen++;
            if (busState != 3'd0 || datGnt || cmdGnt) nonIdleSeen++;
        end
    end

    task automatic clearSeen();
        secSeen = 0; busySeen = 0; abortSeen = 0; toSeen = 0; nonIdleSeen = 0;
    endtask

    initial begin
        applyStimulus(2);
        reset = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_state", 16'(busState), 16'd0);
        checkOutput("reset_outputs", 16'({cmdGnt, datGnt, abortPulse, timeoutErr, securityErr}), 16'd0);

        // Tie: command wins first, data wins the next tie
        cmdReq = 1'b1; datReq = 1'b1;
        applyStimulus(1);
        checkOutput("tie_first_cmd", 16'({cmdGnt, datGnt}), 16'b10);
        cmdDone = 1'b1; busyChk = 1'b0;
        applyStimulus(1);
        cmdDone = 1'b0;
        checkOutput("cmd_done_idle", 16'(busState), 16'd0);
        applyStimulus(1);
        checkOutput("tie_second_dat", 16'({cmdGnt, datGnt}), 16'b01);
        cmdReq = 1'b0; datReq = 1'b0; datDone = 1'b1;
        applyStimulus(1);
        datDone = 1'b0;
        applyStimulus(1);

        // Security rejection for three request cycles
        clearSeen();
        datReq = 1'b1; accessGranted = 1'b0;
        applyStimulus(3);
        datReq = 1'b0; accessGranted = 1'b1;
        applyStimulus(2);
        checkOutput("sec_pulses", 16'(secSeen), 16'd3);
        checkOutput("sec_no_grant", 16'(nonIdleSeen), 16'd0);

        // Busy wait: DAT0 low 10 cycles then high
        timeoutLimit = 16'd100;
        cmdReq = 1'b1;
        applyStimulus(1);
        cmdReq = 1'b0;
        clearSeen();
        cmdDone = 1'b1; busyChk = 1'b1; dat0 = 1'b0;
        applyStimulus(1);
        cmdDone = 1'b0; busyChk = 1'b0;
        applyStimulus(10);
        dat0 = 1'b1;
        applyStimulus(4);
        checkOutput("busy_cycles", 16'(busySeen), 16'd12);
        checkOutput("busy_no_timeout", 16'(toSeen), 16'd0);
        checkOutput("busy_exit_idle", 16'(busState), 16'd0);

        // Busy wait with a short limit and DAT0 held low
        timeoutLimit = 16'd5;
        datReq = 1'b1;
        applyStimulus(1);
        datReq = 1'b0;
        clearSeen();
        datDone = 1'b1; busyChk = 1'b1; dat0 = 1'b0;
        applyStimulus(1);
        datDone = 1'b0; busyChk = 1'b0;
        applyStimulus(10);
`ifdef SDCARD_ARB_BUSY_TIMEOUT_EN
        checkOutput("timeout_state", 16'(busState), 16'd0);
        checkOutput("timeout_pulses", 16'(toSeen), 16'd1);
        checkOutput("timeout_abort", 16'(abortSeen), 16'd1);
`else
        checkOutput("no_timeout_state", 16'(busState), 16'd3);
        checkOutput("no_timeout_pulses", 16'(toSeen), 16'd0);
`endif
        dat0 = 1'b1;
        applyStimulus(3);
        checkOutput("after_timeout_idle", 16'(busState), 16'd0);
        timeoutLimit = 16'd100;

        // Card removed together with the data done pulse
        datReq = 1'b1;
        applyStimulus(1);
        datReq = 1'b0;
        checkOutput("data_owner", 16'(datGnt), 16'd1);
        cardPresent = 1'b0; datDone = 1'b1;
        applyStimulus(1);
        datDone = 1'b0; cardPresent = 1'b1;
        checkOutput("card_abort", 16'({busState, abortPulse, datGnt}), 16'({3'd4, 1'b1, 1'b0}));
        applyStimulus(1);
        checkOutput("card_abort_idle", 16'(busState), 16'd0);

        // Reset in the middle of a busy wait
        cmdReq = 1'b1;
        applyStimulus(1);
        cmdReq = 1'b0; cmdDone = 1'b1; busyChk = 1'b1; dat0 = 1'b0;
        applyStimulus(1);
        cmdDone = 1'b0; busyChk = 1'b0;
        applyStimulus(2);
        checkOutput("pre_reset_busy", 16'(busState), 16'd3);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0; dat0 = 1'b1;
        checkOutput("reset_busy_state", 16'(busState), 16'd0);
        checkOutput("reset_busy_outs", 16'({cmdGnt, datGnt, abortPulse, timeoutErr, securityErr}), 16'd0);
        applyStimulus(1);

        // Power-down from idle ignores requests, then power-down aborts a command
        powerDown = 1'b1;
        applyStimulus(1);
        clearSeen();
        cmdReq = 1'b1; accessGranted = 1'b0;
        applyStimulus(2);
        checkOutput("pwrdn_state", 16'(busState), 16'd5);
        checkOutput("pwrdn_no_sec", 16'(secSeen), 16'd0);
        powerDown = 1'b0; cmdReq = 1'b0; accessGranted = 1'b1;
        applyStimulus(1);
        cmdReq = 1'b1;
        applyStimulus(1);
        cmdReq = 1'b0; powerDown = 1'b1;
        applyStimulus(1);
        checkOutput("pd_abort", 16'(abortPulse), 16'd1);
        applyStimulus(1);
        checkOutput("pd_to_pwrdn", 16'(busState), 16'd5);
        powerDown = 1'b0;
        applyStimulus(1);

        // Card absent in idle, then non-owner done ignored
        cardPresent = 1'b0; cmdReq = 1'b1;
        applyStimulus(2);
        checkOutput("no_card_idle", 16'(busState), 16'd0);
        cardPresent = 1'b1;
        applyStimulus(1);
        cmdReq = 1'b0; datDone = 1'b1;
        applyStimulus(1);
        datDone = 1'b0;
        checkOutput("nonowner_done", 16'(busState), 16'd1);
        cmdDone = 1'b1;
        applyStimulus(1);
        cmdDone = 1'b0;
        applyStimulus(2);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
